// File: rtl/l1_tlb_refill_ctrl_pkg.sv
// Shared types and constants for the L1 TLB refill controller slice.
package l1_tlb_refill_ctrl_pkg;

  localparam int unsigned ENTRIES = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned VPN_W   = 27;
  localparam int unsigned TREE_W  = ENTRIES - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Lowest-index invalid entry; bit IDX_W is set when any entry is free.
  function automatic logic [IDX_W:0] first_free(input logic [ENTRIES-1:0] v);
    logic [IDX_W:0] r;
    casez (v)
      8'b???????0: r = {1'b1, 3'd0};
      8'b??????01: r = {1'b1, 3'd1};
      8'b?????011: r = {1'b1, 3'd2};
      8'b????0111: r = {1'b1, 3'd3};
      8'b???01111: r = {1'b1, 3'd4};
      8'b??011111: r = {1'b1, 3'd5};
      8'b?0111111: r = {1'b1, 3'd6};
      8'b01111111: r = {1'b1, 3'd7};
      default:     r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/l1_tlb_refill_ctrl_if.sv
// Lookup, L2 TLB handshake and refill signals of the refill controller.
interface l1_tlb_refill_ctrl_if;
  import l1_tlb_refill_ctrl_pkg::*;

  logic               io_req_valid;
  logic [VPN_W-1:0]   io_req_vpn;
  logic               io_hit;
  logic [IDX_W-1:0]   io_hit_idx;
  logic [ENTRIES-1:0] valid;
  logic               io_ptw_invalidate;
  logic               io_l2tlb_req_valid;
  logic               io_l2tlb_req_ready;
  logic [VPN_W-1:0]   io_l2tlb_req_bits_vpn;
  logic               io_l2tlb_resp_valid;
  logic               io_refill_valid;
  logic [IDX_W-1:0]   r_refill_waddr;
  logic [VPN_W-1:0]   r_refill_tag;
  logic               io_miss_stall;

  modport slave (
    input  io_req_valid, io_req_vpn, io_hit, io_hit_idx, valid,
           io_ptw_invalidate, io_l2tlb_req_ready, io_l2tlb_resp_valid,
    output io_l2tlb_req_valid, io_l2tlb_req_bits_vpn, io_refill_valid,
           r_refill_waddr, r_refill_tag, io_miss_stall
  );

  modport master (
    output io_req_valid, io_req_vpn, io_hit, io_hit_idx, valid,
           io_ptw_invalidate, io_l2tlb_req_ready, io_l2tlb_resp_valid,
    input  io_l2tlb_req_valid, io_l2tlb_req_bits_vpn, io_refill_valid,
           r_refill_waddr, r_refill_tag, io_miss_stall
  );

endinterface

// File: rtl/l1_tlb_refill_ctrl_repl.sv
// Victim selection and replacement state for the L1 TLB.
// L1TLB_PLRU_EN: 7-bit tree pseudo-LRU; otherwise 3-bit round-robin.
module l1_tlb_repl
  import l1_tlb_refill_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [ENTRIES-1:0] valid,
  input  logic               hit_touch,
  input  logic [IDX_W-1:0]   hit_idx,
  input  logic               refill_touch,
  input  logic [IDX_W-1:0]   refill_idx,
  output logic [IDX_W-1:0]   victim
);

  logic [IDX_W:0]   free;
  logic [IDX_W-1:0] repl_idx;

  assign free = first_free(valid);

  // Free entries always win over the replacement policy.
  always_comb begin
    victim = free[IDX_W] ? free[IDX_W-1:0] : repl_idx;
  end

`ifdef L1TLB_PLRU_EN
  logic [TREE_W-1:0] tree_q;
  logic [TREE_W-1:0] tree_d;

  // Each node bit points at the half holding the next victim (1 = upper);
  // a touch points every node on the path away from the touched leaf.
  function automatic logic [TREE_W-1:0] touch(input logic [TREE_W-1:0] t,
                                              input logic [IDX_W-1:0]  idx);
    logic [TREE_W-1:0] r;
    logic [2:0]        n1;
    logic [2:0]        n2;
    r     = t;
    r[0]  = ~idx[2];
    n1    = idx[2] ? 3'd2 : 3'd1;
    r[n1] = ~idx[1];
    n2    = {n1[1:0], 1'b0} + (idx[1] ? 3'd2 : 3'd1);
    r[n2] = ~idx[0];
    return r;
  endfunction

  // Tree walk from the root to the pseudo-least-recently-used leaf.
  always_comb begin
    logic [2:0] n1;
    logic [2:0] n2;
    n1       = tree_q[0] ? 3'd2 : 3'd1;
    n2       = {n1[1:0], 1'b0} + (tree_q[n1] ? 3'd2 : 3'd1);
    repl_idx = {tree_q[0], tree_q[n1], tree_q[n2]};
  end

  // Hit touch first, refill touch last so the refilled entry is most recent.
  always_comb begin
    tree_d = tree_q;
    if (hit_touch)    tree_d = touch(tree_d, hit_idx);
    if (refill_touch) tree_d = touch(tree_d, refill_idx);
  end

  // Tree state register.
  always_ff @(posedge clk) begin
    if (!reset) tree_q <= '0;
    else        tree_q <= tree_d;
  end
`else
  logic [IDX_W-1:0] rr_q;
  logic             unused_hit_sink;

  // Hits carry no information for round-robin replacement.
  assign unused_hit_sink = ^{hit_touch, hit_idx, refill_idx};
  assign repl_idx        = rr_q;

  // Round-robin pointer advances once per completed refill, wrapping 7->0.
  always_ff @(posedge clk) begin
    if (!reset)            rr_q <= '0;
    else if (refill_touch) rr_q <= rr_q + 3'd1;
  end
`endif

endmodule

// File: rtl/l1_tlb_refill_ctrl.sv
// L1 TLB miss/refill controller: captures a miss, issues it to the L2 TLB,
// and gates the response into a one-cycle refill strobe.
// Replacement policy selected by L1TLB_PLRU_EN (see l1_tlb_repl).
module l1_tlb_refill_ctrl
  import l1_tlb_refill_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  l1_tlb_refill_ctrl_if.slave  bus
);

  state_t           state_q;
  logic             kill_q;
  logic             req_valid_q;
  logic             stall_q;
  logic [VPN_W-1:0] tag_q;
  logic [IDX_W-1:0] waddr_q;
  logic [IDX_W-1:0] victim;
  logic             miss_accept;
  logic             refill;

  // A miss is taken only from IDLE and never alongside a flush.
  always_comb begin
    miss_accept = (state_q == IDLE) && bus.io_req_valid && !bus.io_hit &&
                  !bus.io_ptw_invalidate;
  end

  // Response is forwarded only in WAIT for an un-flushed request.
  always_comb begin
    refill = bus.io_l2tlb_resp_valid && (state_q == WAIT) && !kill_q &&
             !bus.io_ptw_invalidate;
  end

  l1_tlb_repl u_repl (
    .clk          (clk),
    .reset        (reset),
    .valid        (bus.valid),
    .hit_touch    (bus.io_req_valid & bus.io_hit),
    .hit_idx      (bus.io_hit_idx),
    .refill_touch (refill),
    .refill_idx   (waddr_q),
    .victim       (victim)
  );

  // Miss FSM with registered request/stall outputs.
  // A flushed request still finishes the L2 handshake; kill only drops the refill.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      kill_q      <= 1'b0;
      req_valid_q <= 1'b0;
      stall_q     <= 1'b0;
      tag_q       <= '0;
      waddr_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_accept) begin
            state_q     <= REQ;
            tag_q       <= bus.io_req_vpn;
            waddr_q     <= victim;
            req_valid_q <= 1'b1;
            stall_q     <= 1'b1;
          end
        end
        REQ: begin
          if (bus.io_ptw_invalidate) kill_q <= 1'b1;
          if (bus.io_l2tlb_req_ready) begin
            state_q     <= WAIT;
            req_valid_q <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.io_ptw_invalidate) kill_q <= 1'b1;
          if (bus.io_l2tlb_resp_valid) begin
            state_q <= IDLE;
            kill_q  <= 1'b0;
            stall_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          kill_q      <= 1'b0;
          req_valid_q <= 1'b0;
          stall_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.io_l2tlb_req_valid    = req_valid_q;
  assign bus.io_l2tlb_req_bits_vpn = tag_q;
  assign bus.io_refill_valid       = refill;
  assign bus.r_refill_waddr        = waddr_q;
  assign bus.r_refill_tag          = tag_q;
  assign bus.io_miss_stall         = stall_q;

endmodule
